// File: rtl/piso_shift_tx8.sv
// Parallel-in / serial-out transmitter: takes a word through a load/ready
// handshake and streams it one bit per clock, framed by out_valid with done on the last bit.
module piso_shift_tx8 #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] par_data,
    output logic             ready,
    output logic             out_data,
    output logic             out_valid,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic             data_next, valid_next, done_next;
    logic             last_bit, accept;

    // The shift register holds the bits still to send after the one on out_data.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign last_bit = (state == SHIFT) && (cnt == LAST);
    assign ready    = (state == IDLE) || last_bit;
    assign accept   = load && ready;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            out_data  <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            shreg     <= shreg_next;
            cnt       <= cnt_next;
            out_data  <= data_next;
            out_valid <= valid_next;
            done      <= done_next;
        end
    end

    // Accepting in the last-bit cycle chains the next word with no idle gap.
    always_comb begin
        state_next = state;
        shreg_next = shreg;
        cnt_next   = cnt;
        data_next  = out_data;
        valid_next = out_valid;
        done_next  = done;
        if (accept) begin
            state_next = SHIFT;
            shreg_next = advance(par_data);
            cnt_next   = '0;
            data_next  = first_bit(par_data);
            valid_next = 1'b1;
            done_next  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    data_next  = 1'b0;
                    valid_next = 1'b0;
                    done_next  = 1'b0;
                end
                SHIFT: begin
                    if (last_bit) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                        data_next  = 1'b0;
                        valid_next = 1'b0;
                        done_next  = 1'b0;
                    end else begin
                        cnt_next   = cnt + CW'(1);
                        shreg_next = advance(shreg);
                        data_next  = first_bit(shreg);
                        valid_next = 1'b1;
                        done_next  = ((cnt + CW'(1)) == LAST);
                    end
                end
                default: begin
                    state_next = IDLE;
                    data_next  = 1'b0;
                    valid_next = 1'b0;
                    done_next  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_shift_tx8.sv
// Scoreboard bench for piso_shift_tx8: an MSB-first and an LSB-first instance,
// expected bits queued at each accepting edge and popped on every valid output cycle.
module tb_piso_shift_tx8;

    typedef struct {
        logic d;
        logic last;
    } exp_t;

    logic       Clk;
    logic       reset;
    logic       load_m, load_l;
    logic [7:0] par_m, par_l;
    logic       ready_m, data_m, valid_m, done_m;
    logic       ready_l, data_l, valid_l, done_l;

    exp_t q_m[$];
    exp_t q_l[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;

    piso_shift_tx8 #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .Clk(Clk), .reset(reset), .load(load_m), .par_data(par_m),
        .ready(ready_m), .out_data(data_m), .out_valid(valid_m), .done(done_m)
    );

    piso_shift_tx8 #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .Clk(Clk), .reset(reset), .load(load_l), .par_data(par_l),
        .ready(ready_l), .out_data(data_l), .out_valid(valid_l), .done(done_l)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drives one word a cycle ahead of the accepting edge and queues its bits on that edge.
    task automatic applyStimulus(input int lane, input logic [7:0] word);
        exp_t e;
        @(posedge Clk);
        #1;
        if (lane == 0) begin load_m = 1'b1; par_m = word; end
        else           begin load_l = 1'b1; par_l = word; end
        @(posedge Clk);
        for (int i = 0; i < 8; i++) begin
            e.d    = (lane == 0) ? word[7-i] : word[i];
            e.last = (i == 7);
            if (lane == 0) q_m.push_back(e);
            else           q_l.push_back(e);
        end
        #1;
        if (lane == 0) begin load_m = 1'b0; par_m = ~word; end
        else           begin load_l = 1'b0; par_l = ~word; end
    endtask

    task automatic drain();
        int budget = 40;
        while ((q_m.size() != 0 || q_l.size() != 0) && budget > 0) begin
            @(posedge Clk);
            budget--;
        end
        checkOutput("drain_timeout", 8'(q_m.size() + q_l.size()), 8'd0);
        repeat (2) @(posedge Clk);
    endtask

    task automatic checkLane(input string name, input int lane,
                             input logic v, input logic d, input logic dn, input logic rdy);
        exp_t e;
        int   sz;
        sz = (lane == 0) ? q_m.size() : q_l.size();
        if (v === 1'b1) begin
            if (sz == 0) begin
                checkOutput({name, "_spurious_valid"}, 8'(v), 8'd0);
            end else begin
                if (lane == 0) e = q_m.pop_front();
                else           e = q_l.pop_front();
                checkOutput({name, "_data"}, 8'(d), 8'(e.d));
                checkOutput({name, "_done"}, 8'(dn), 8'(e.last));
                checkOutput({name, "_ready"}, 8'(rdy), 8'(e.last));
            end
        end else begin
            if (sz != 0) checkOutput({name, "_missing_valid"}, 8'(v), 8'd1);
            checkOutput({name, "_idle_data"}, 8'(d), 8'd0);
            checkOutput({name, "_idle_done"}, 8'(dn), 8'd0);
            checkOutput({name, "_idle_ready"}, 8'(rdy), 8'd1);
        end
    endtask

    // Output monitor samples on the falling edge, away from register updates.
    always @(negedge Clk) begin
        if (mon_en && !reset) begin
            checkLane("msb", 0, valid_m, data_m, done_m, ready_m);
            checkLane("lsb", 1, valid_l, data_l, done_l, ready_l);
        end
    end

    initial begin
        reset  = 1'b0;
        load_m = 1'b0; load_l = 1'b0;
        par_m  = 8'h00; par_l = 8'h00;

        #2 reset = 1'b1;
        #1;
        checkOutput("por_data",  8'(data_m),  8'd0);
        checkOutput("por_valid", 8'(valid_m), 8'd0);
        checkOutput("por_done",  8'(done_m),  8'd0);
        checkOutput("por_lsb_valid", 8'(valid_l), 8'd0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        #1 reset = 1'b0;
        #1;
        checkOutput("por_ready_msb", 8'(ready_m), 8'd1);
        checkOutput("por_ready_lsb", 8'(ready_l), 8'd1);
        mon_en = 1'b1;

        // Single word, MSB first.
        applyStimulus(0, 8'hA5);
        drain();

        // Back-to-back: second word loaded in the last-bit cycle of the first.
        applyStimulus(0, 8'hA5);
        repeat (6) @(posedge Clk);
        applyStimulus(0, 8'h3C);
        drain();

        // A load mid-word must be ignored.
        applyStimulus(0, 8'hA5);
        repeat (3) @(posedge Clk);
        #1;
        load_m = 1'b1; par_m = 8'hFF;
        @(posedge Clk);
        #1;
        load_m = 1'b0;
        drain();

        // Asynchronous reset in the middle of a word.
        applyStimulus(0, 8'hA5);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        #2 reset = 1'b1;
        q_m.delete();
        #1;
        checkOutput("midreset_data",  8'(data_m),  8'd0);
        checkOutput("midreset_valid", 8'(valid_m), 8'd0);
        checkOutput("midreset_done",  8'(done_m),  8'd0);
        #1 reset = 1'b0;
        #1;
        checkOutput("midreset_ready", 8'(ready_m), 8'd1);
        applyStimulus(0, 8'h81);
        drain();

        // LSB-first instance.
        applyStimulus(1, 8'h01);
        drain();
        applyStimulus(1, 8'hB2);
        drain();

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
